// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the recursive Fibonacci engine.
// Holds the controller state encoding, the leaf threshold and the default
// parameter values used by the interface and the engine.
package fib_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_EVAL  = 3'd2,
        ST_PUSH2 = 3'd3,
        ST_DONE  = 3'd4
    } fib_state_e;

    // Values below this threshold are leaves of the recursion
    localparam int FIB_LEAF_THR = 2;

    // Default configuration
    localparam int DEF_N_W         = 4;
    localparam int DEF_RES_W       = 16;
    localparam int DEF_STACK_DEPTH = 16;

endpackage : fib_pkg

// File: rtl/fib_engine_if.sv
// fib_engine_if: start/done handshake plus result/status bundle of fib_engine.
// master = requester (drives start/n), slave = the engine.
interface fib_engine_if
    import fib_pkg::*;
#(
    parameter int N_W   = DEF_N_W,
    parameter int RES_W = DEF_RES_W
);
    logic             start;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             overflow;
    logic             err;

    modport master (
        output start, n,
        input  busy, done, result, overflow, err
    );

    modport slave (
        input  start, n,
        output busy, done, result, overflow, err
    );
endinterface : fib_engine_if

// File: rtl/fib_stack.sv
// fib_stack: parametrised LIFO with synchronous write and a combinational
// top/empty/full view. The pointer counts occupied entries (0..DEPTH).
// A push while full is dropped (nothing is written, pointer unchanged).
module fib_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);

    logic [PW-1:0]    sp_r;
    logic [PW-1:0]    sp_m1_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty   = (sp_r == {PW{1'b0}});
    assign full    = (sp_r == PW'(DEPTH));
    assign sp_m1_s = sp_r - PW'(1);
    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;
    // The top entry is only meaningful when not empty; present zero otherwise
    assign top     = empty ? {WIDTH{1'b0}} : mem_r[sp_m1_s[AW-1:0]];

    // Stack pointer: up on accepted push, down on accepted pop
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r <= {PW{1'b0}};
        end else if (wr_en_s) begin
            sp_r <= sp_r + PW'(1);
        end else if (rd_en_s) begin
            sp_r <= sp_m1_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Storage write at the current free slot
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[sp_r[AW-1:0]] <= d_in;
        end
    end

    fib_stack_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop)
    );

endmodule : fib_stack

// File: rtl/fib_stack_chk.sv
// fib_stack_chk: simulation checks on the LIFO control inputs.
// The controller must never request a push and a pop in the same cycle.
module fib_stack_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop
);

    // push and pop are mutually exclusive outside reset
    a_no_push_and_pop: assert property (@(posedge clk) disable iff (rst) !(push && pop))
        else $error("fib_stack: push and pop asserted together");

endmodule : fib_stack_chk

// File: rtl/fib_engine.sv
// fib_engine: computes fib(n) by explicit stack recursion.
// Pop x; a leaf (x < 2) adds x to the accumulator; otherwise push x-1, x-2.
// Optional feature macro: FIB_SAT_EN -- accumulator saturates at all-ones on
// carry-out instead of wrapping; overflow is reported in both builds.
module fib_engine
    import fib_pkg::*;
#(
    parameter int N_W         = DEF_N_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    fib_engine_if.slave bus
);

    localparam int SW = RES_W + 1;

    fib_state_e       state_r;
    logic [N_W-1:0]   x_r;
    logic [RES_W-1:0] result_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic             err_r;

    logic             push_s;
    logic             pop_s;
    logic [N_W-1:0]   din_s;
    logic [N_W-1:0]   top_s;
    logic             empty_s;
    logic             full_s;
    logic             stk_rst_s;
    logic             leaf_s;
    logic [N_W-1:0]   x_m1_s;
    logic [N_W-1:0]   x_m2_s;
    logic [SW-1:0]    sum_s;
    logic [RES_W-1:0] acc_next_s;

    assign leaf_s = (int'(x_r) < FIB_LEAF_THR);
    assign x_m1_s = x_r - N_W'(1);
    assign x_m2_s = x_r - N_W'(FIB_LEAF_THR);
    // The stack is also emptied in DONE so an aborted run leaves nothing behind
    assign stk_rst_s = rst || (state_r == ST_DONE);

    // Stack control decoded from the current state
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        din_s  = {N_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                push_s = bus.start;
                din_s  = bus.n;
            end
            ST_POP: begin
                pop_s = !empty_s;
            end
            ST_EVAL: begin
                push_s = !leaf_s && !full_s;
                din_s  = x_m1_s;
            end
            ST_PUSH2: begin
                push_s = !full_s;
                din_s  = x_m2_s;
            end
            default: begin
                push_s = 1'b0;
                pop_s  = 1'b0;
                din_s  = {N_W{1'b0}};
            end
        endcase
    end

    // Accumulator next value: wrap or saturate on carry-out
    always_comb begin
        sum_s = {1'b0, result_r} + SW'(x_r);
`ifdef FIB_SAT_EN
        acc_next_s = sum_s[RES_W] ? {RES_W{1'b1}} : sum_s[RES_W-1:0];
`else
        acc_next_s = sum_s[RES_W-1:0];
`endif
    end

    // Controller FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            x_r      <= {N_W{1'b0}};
            result_r <= {RES_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        result_r <= {RES_W{1'b0}};
                        ovf_r    <= 1'b0;
                        err_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_POP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    if (empty_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        x_r     <= top_s;
                        state_r <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (leaf_s) begin
                        result_r <= acc_next_s;
                        if (sum_s[RES_W]) begin
                            ovf_r <= 1'b1;
                        end
                        state_r  <= ST_POP;
                    end else if (full_s) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_PUSH2;
                    end
                end
                ST_PUSH2: begin
                    if (full_s) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_POP;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    fib_stack #(
        .WIDTH (N_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (stk_rst_s),
        .push  (push_s),
        .pop   (pop_s),
        .d_in  (din_s),
        .top   (top_s),
        .empty (empty_s),
        .full  (full_s)
    );

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.overflow = ovf_r;
    assign bus.err      = err_r;

endmodule : fib_engine

// File: tb/tb_fib_engine.sv
// tb_fib_engine: scoreboard bench for fib_engine.
// Three instances: A (4/16/16), B (RES_W=4, overflow), C (STACK_DEPTH=2, stack error).
// Expectations are pushed when a start is driven and popped on done.
module tb_fib_engine;

    typedef struct {
        int unsigned res;
        bit          ovf;
        bit          err;
        bit          chk;
        int          acc_cyc;
        int          done_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_vec  = 0;
    int n_miss = 0;

    sb_t sb_q[$];
    sb_t mon_e;
    int  cur_sel  = 0;
    bit  busy_gap = 1'b0;
    int  done_cnt = 0;

    logic        m_done;
    logic        m_busy;
    logic        m_ovf;
    logic        m_err;
    logic [15:0] m_res;

    fib_engine_if #(.N_W(4), .RES_W(16)) if_a ();
    fib_engine_if #(.N_W(4), .RES_W(4))  if_b ();
    fib_engine_if #(.N_W(4), .RES_W(16)) if_c ();

    fib_engine #(.N_W(4), .RES_W(16), .STACK_DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    fib_engine #(.N_W(4), .RES_W(4),  .STACK_DEPTH(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    fib_engine #(.N_W(4), .RES_W(16), .STACK_DEPTH(2))  dut_c (.clk(clk), .rst(rst), .bus(if_c));

    always #5 clk = ~clk;

    // cycle counter, one per rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // observe outputs of the instance currently under test
    always_comb begin
        m_done = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_res = 16'd0;
        case (cur_sel)
            0: begin m_done = if_a.done; m_busy = if_a.busy; m_ovf = if_a.overflow;
                     m_err = if_a.err; m_res = if_a.result; end
            1: begin m_done = if_b.done; m_busy = if_b.busy; m_ovf = if_b.overflow;
                     m_err = if_b.err; m_res = {12'd0, if_b.result}; end
            default: begin m_done = if_c.done; m_busy = if_c.busy; m_ovf = if_c.overflow;
                     m_err = if_c.err; m_res = if_c.result; end
        endcase
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    // Reference: fib by iteration, stack error by replaying the pop/push order
    function automatic sb_t model(input int sel, input int nv);
        sb_t     e;
        int      depth;
        int      resw;
        int      st[64];
        int      sp;
        int      x;
        bit      er;
        longint  f0;
        longint  f1;
        longint  t;
        longint  maxv;
        longint  leaves;
        depth = (sel == 2) ? 2 : 16;
        resw  = (sel == 1) ? 4 : 16;
        f0 = 0; f1 = 1;
        for (int i = 0; i < nv; i++) begin
            t = f0 + f1; f0 = f1; f1 = t;
        end
        leaves = f1;
        sp = 0; st[0] = nv; sp = 1; er = 1'b0;
        while (sp > 0 && !er) begin
            sp = sp - 1;
            x  = st[sp];
            if (x >= 2) begin
                if (sp >= depth) er = 1'b1;
                else begin
                    st[sp] = x - 1; sp = sp + 1;
                    if (sp >= depth) er = 1'b1;
                    else begin st[sp] = x - 2; sp = sp + 1; end
                end
            end
        end
        maxv  = (64'sd1 <<< resw) - 1;
        e.err = er;
        e.chk = !er;
        e.ovf = (f0 > maxv);
`ifdef FIB_SAT_EN
        e.res = e.ovf ? int'(maxv) : int'(f0);
`else
        e.res = int'(f0 & maxv);
`endif
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + int'(2 * leaves + 3 * (leaves - 1) + 2);
        return e;
    endfunction

    // Scoreboard side: track busy during a run, compare on every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && cyc >= sb_q[0].acc_cyc && !m_busy) busy_gap = 1'b1;
            if (m_done) begin
                done_cnt++;
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check_val("err", longint'(m_err), longint'(mon_e.err));
                    check_val("busy_run", longint'(busy_gap), 0);
                    if (mon_e.chk) begin
                        check_val("result", longint'(m_res), longint'(mon_e.res));
                        check_val("overflow", longint'(m_ovf), longint'(mon_e.ovf));
                        check_val("done_cycle", longint'(cyc), longint'(mon_e.done_cyc));
                    end
                    busy_gap = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; waits for the instance to be idle, then drives one start pulse
    task automatic start_run(input int sel, input int nv);
        int guard;
        guard = 0;
        while (get_busy(sel) && guard < 20000) begin
            @(negedge clk); guard++;
        end
        cur_sel = sel;
        sb_q.push_back(model(sel, nv));
        case (sel)
            0:       begin if_a.start = 1'b1; if_a.n = 4'(nv); end
            1:       begin if_b.start = 1'b1; if_b.n = 4'(nv); end
            default: begin if_c.start = 1'b1; if_c.n = 4'(nv); end
        endcase
        @(negedge clk);
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 20000) begin
            @(negedge clk); guard++;
        end
        check_val("drain", longint'(sb_q.size()), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic check_zero_a(input string tag);
        check_val({tag, "_busy"},     longint'(if_a.busy), 0);
        check_val({tag, "_done"},     longint'(if_a.done), 0);
        check_val({tag, "_result"},   longint'(if_a.result), 0);
        check_val({tag, "_overflow"}, longint'(if_a.overflow), 0);
        check_val({tag, "_err"},      longint'(if_a.err), 0);
    endtask

    initial begin
        int snap;
        if_a.start = 1'b0; if_a.n = 4'd0;
        if_b.start = 1'b0; if_b.n = 4'd0;
        if_c.start = 1'b0; if_c.n = 4'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_a("reset");

        // basic runs, including back-to-back n=1 then n=5
        start_run(0, 0);  wait_idle();
        start_run(0, 1);  start_run(0, 5);  wait_idle();
        start_run(0, 3);  wait_idle();
        start_run(0, 15); wait_idle();

        // narrow accumulator: overflow with and without saturation
        start_run(1, 8);  wait_idle();
        start_run(1, 6);  wait_idle();

        // shallow stack: error then a clean run
        start_run(2, 6);  wait_idle();
        start_run(2, 2);  wait_idle();

        // start while busy is ignored
        start_run(0, 5);
        repeat (4) @(negedge clk);
        if_a.start = 1'b1; if_a.n = 4'd3;
        @(negedge clk);
        if_a.start = 1'b0;
        wait_idle();

        // reset mid-run: outputs cleared, no done pulse afterwards
        start_run(0, 7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        busy_gap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        snap = done_cnt;
        check_zero_a("midrst");
        repeat (60) @(negedge clk);
        check_val("no_done_after_rst", longint'(done_cnt - snap), 0);
        check_val("idle_after_rst", longint'(if_a.busy), 0);

        // recovery after reset
        start_run(0, 4);  wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fib_engine

// File: doc/fib_engine.md
# fib_engine

Parametrised recursive Fibonacci engine. The block evaluates fib(n) by explicit stack-based recursion: pop x; a leaf (x < 2) adds x to an accumulator; any other value pushes x-1 and x-2. It generalises the fixed 3-bit Fibonacci datapath to configurable operand width, result width and stack depth. It has an integrated controller FSM, a start/done handshake, and stack-overflow and arithmetic-overflow reporting.

## Interface
- N_W, 4: width of operand n.
- RES_W, 16: width of result accumulator.
- STACK_DEPTH, 16: LIFO entries, each N_W bits wide. STACK_DEPTH >= 2^N_W guarantees no stack error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a computation; sampled only in IDLE.
- n  in  N_W  operand; captured on the accepting edge.
- busy  out  1  high from the accepting edge until DONE exits.
- done  out  1  one-cycle pulse; result is valid from this cycle on.
- result  out  RES_W  accumulator; holds its value until the next accepted start.
- overflow  out  1  sticky per run; accumulator exceeded 2^RES_W-1.
- err  out  1  sticky per run; a push was attempted while the stack was full.

## Operation
- States: IDLE, POP, EVAL, PUSH2, DONE.
- IDLE, start=1: push n, clear result/overflow/err, busy<=1, go to POP. IDLE, start=0: stay.
- POP, stack empty: go to DONE.
- POP, stack not empty: x <= top, pop, go to EVAL.
- EVAL, x < 2: result += x, go to POP.
- EVAL, x >= 2: push x-1, go to PUSH2.
- PUSH2: push x-2, go to POP.
- DONE: done=1, busy<=0, go to IDLE.
- Leaf test: x < 2, i.e. bits [N_W-1:1] all zero.
- x-1 and x-2 are N_W-bit; x-2 cannot underflow because x >= 2 in EVAL.
- Accumulation: RES_W-bit add of the zero-extended x. Carry-out sets overflow (behaviour per Configuration).
- Push while full: err<=1, nothing is written, FSM goes to DONE next cycle. result is then don't-care.
- start while busy: ignored; n is not re-sampled.
- rst (any state, including mid-run): state=IDLE, stack pointer=0, result=0, busy=0, done=0, overflow=0, err=0.

## Timing
- Reset values: all outputs 0.
- Stack is synchronous-write with a combinational top/empty/full read. The pointer updates on the push/pop edge.
- Per recursion node: a leaf costs 2 cycles (POP, EVAL); an internal node costs 3 cycles (POP, EVAL, PUSH2).
- With L = fib(n+1) leaves and I = L-1 internal nodes, done is high in cycle 2L+3I+2 after the accepting edge.
  - n=0: cycle 4.
  - n=1: cycle 4.
  - n=3: cycle 14.
  - n=5: cycle 39.
- Earliest next accept: the cycle after done (back-to-back start allowed).
- result and overflow are stable throughout the done cycle and afterwards until the next accept.

## Configuration
- FIB_SAT_EN defined:
  - The accumulator saturates at 2^RES_W-1 on carry-out.
  - overflow is set and stays set for the run.
- FIB_SAT_EN undefined:
  - The accumulator wraps modulo 2^RES_W.
  - overflow is still set on any carry-out.

## Structure
- Package fib_pkg holds:
  - the state enum (IDLE, POP, EVAL, PUSH2, DONE);
  - the leaf threshold constant (2);
  - the default parameter constants.
- Sub-module fib_stack: parametrised LIFO (WIDTH, DEPTH). Ports: clk, rst, push, pop, d_in, top, empty, full.
  - Push and pop in the same cycle: illegal; the controller never issues it. Assert it in simulation.
- fib_engine contains the FSM, the x register, the decrement logic and the accumulator.

## Test plan
- Reset, then start with n=0: done in cycle 4, result=0, overflow=0, err=0.
- start with n=1, then with n=5 (back-to-back): results 1 then 5; n=5 done in cycle 39; busy high throughout each run.
- N_W=4, RES_W=16, n=15: result=610, done in cycle 4934, err=0.
- RES_W=4, n=8:
  - FIB_SAT_EN defined: result=15, overflow=1.
  - FIB_SAT_EN undefined: result=5, overflow=1.
- STACK_DEPTH=2, n=6: err=1 with done pulse; then n=2 gives result=1, err=0.
- Disturbances:
  - Pulse start with n=3 at cycle 5 of an n=5 run: ignored, final result=5.
  - Assert rst at cycle 10 of another run: all outputs 0, no done pulse.
